// File: rtl/axi4_burst_master_if.sv
// AXI4 burst bus (AR/R/AW/W/B channels) between axi4_burst_master and memory.
// The master modport is used by axi4_burst_master. The slave modport is the memory side.
interface axi4_burst_master_if #(
    parameter int ADDR_WIDTH     = 64,
    parameter int AXI_DATA_WIDTH = 64
);
    // Read address channel
    logic                        arvalid;
    logic                        arready;
    logic [ADDR_WIDTH-1:0]       araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    // Read data channel
    logic                        rvalid;
    logic                        rready;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    // Write address channel
    logic                        awvalid;
    logic                        awready;
    logic [ADDR_WIDTH-1:0]       awaddr;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;
    // Write data channel
    logic                        wvalid;
    logic                        wready;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wlast;
    // Write response channel
    logic                        bvalid;
    logic                        bready;
    logic [1:0]                  bresp;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast,
        output rready,
        output awvalid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast,
        input  rready,
        input  awvalid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/axi4_burst_master.sv
// axi4_burst_master: turns one cache-block request from the core into a single
// AXI4 INCR burst of BLOCK_WIDTH/AXI_DATA_WIDTH beats and pulses o_axi_done once.
// Optional feature macro: AXI_ERR_CHECK_EN. When it is defined, o_axi_err becomes
// a sticky flag for non-OKAY responses and for rlast on the wrong beat. When it is
// undefined, o_axi_err is tied to 0.
module axi4_burst_master #(
    parameter int ADDR_WIDTH     = 64,
    parameter int BLOCK_WIDTH    = 512,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_axi_read_start,
    input  logic                   i_axi_write_start,
    input  logic [ADDR_WIDTH-1:0]  i_axi_addr,
    input  logic [BLOCK_WIDTH-1:0] i_data_block,
    output logic [BLOCK_WIDTH-1:0] o_data_block,
    output logic                   o_axi_done,
    output logic                   o_axi_err,
    axi4_burst_master_if.master    bus
);

    localparam int BEATS  = BLOCK_WIDTH / AXI_DATA_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFS_W = $clog2(BLOCK_WIDTH / 8);
    localparam int SIZE   = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        WR_RESP,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [BLOCK_WIDTH-1:0] wbuf_q;
    logic [BLOCK_WIDTH-1:0] rblock_q;
    logic [BEAT_W-1:0]      beat_q;
    logic                   aw_done_q;
    logic                   w_done_q;

    logic                   arvalid_c, rready_c, awvalid_c, wvalid_c, wlast_c, bready_c;
    logic                   done_c;
    logic [ADDR_WIDTH-1:0]  aligned_addr;

    // Block-aligned request address: the byte offset inside the block is dropped.
    assign aligned_addr = {i_axi_addr[ADDR_WIDTH-1:OFFS_W], {OFFS_W{1'b0}}};

    logic unused_addr_bits;
    assign unused_addr_bits = ^i_axi_addr[OFFS_W-1:0];

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    // NOTE: every signal gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        arvalid_c = 1'b0;
        rready_c  = 1'b0;
        awvalid_c = 1'b0;
        wvalid_c  = 1'b0;
        wlast_c   = 1'b0;
        bready_c  = 1'b0;
        done_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_axi_write_start) begin
                    state_d = WR;
                end else if (i_axi_read_start) begin
                    state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                arvalid_c = 1'b1;
                if (bus.arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                rready_c = 1'b1;
                if (bus.rvalid && beat_q == LAST_BEAT) begin
                    state_d = DONE;
                end
            end
            WR: begin
                awvalid_c = !aw_done_q;
                wvalid_c  = !w_done_q;
                wlast_c   = !w_done_q && (beat_q == LAST_BEAT);
                // AW and the last W beat may finish in either order or together.
                if ((aw_done_q || bus.awready) &&
                    (w_done_q || (bus.wready && beat_q == LAST_BEAT))) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                bready_c = 1'b1;
                if (bus.bvalid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // One idle-bound cycle so the core can drop its start request first.
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture, beat counting, channel completion flags and read assembly.
    // NOTE: the wide block registers are reset as well, so no data from an
    // interrupted burst is visible after reset.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            addr_q    <= '0;
            wbuf_q    <= '0;
            rblock_q  <= '0;
            beat_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    beat_q    <= '0;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    if (i_axi_write_start) begin
                        addr_q <= aligned_addr;
                        wbuf_q <= i_data_block;
                    end else if (i_axi_read_start) begin
                        addr_q <= aligned_addr;
                    end
                end
                RD_DATA: begin
                    if (bus.rvalid) begin
                        rblock_q[int'(beat_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= bus.rdata;
                        if (beat_q != LAST_BEAT) begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                end
                WR: begin
                    if (awvalid_c && bus.awready) begin
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_c && bus.wready) begin
                        if (beat_q == LAST_BEAT) begin
                            w_done_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AXI_ERR_CHECK_EN
    logic err_q;

    // Sticky error flag: any non-OKAY response or rlast on the wrong beat.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            err_q <= 1'b0;
        end else if (state_q == RD_DATA && bus.rvalid &&
                     (bus.rresp != 2'b00 || bus.rlast != (beat_q == LAST_BEAT))) begin
            err_q <= 1'b1;
        end else if (state_q == WR_RESP && bus.bvalid && bus.bresp != 2'b00) begin
            err_q <= 1'b1;
        end
    end

    assign o_axi_err = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{bus.rresp, bus.rlast, bus.bresp};
    assign o_axi_err   = 1'b0;
`endif

    assign o_data_block = rblock_q;
    assign o_axi_done   = done_c;

    assign bus.arvalid  = arvalid_c;
    assign bus.araddr   = addr_q;
    assign bus.arlen    = 8'(BEATS - 1);
    assign bus.arsize   = 3'(SIZE);
    assign bus.arburst  = 2'b01;
    assign bus.rready   = rready_c;

    assign bus.awvalid  = awvalid_c;
    assign bus.awaddr   = addr_q;
    assign bus.awlen    = 8'(BEATS - 1);
    assign bus.awsize   = 3'(SIZE);
    assign bus.awburst  = 2'b01;
    assign bus.wvalid   = wvalid_c;
    assign bus.wdata    = wbuf_q[int'(beat_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign bus.wstrb    = '1;
    assign bus.wlast    = wlast_c;
    assign bus.bready   = bready_c;

endmodule

// File: doc/axi4_burst_master.md
Name: axi4_burst_master

Overview:
- Sits directly downstream of the core top level and is the memory-side consumer of the cache FSM's AXI requests.
- Converts each single-cycle-addressed block request (read_start / write_start, block address, 512-bit block) into one AXI4 INCR burst of BLOCK_WIDTH/AXI_DATA_WIDTH beats.
- Returns a one-cycle done pulse plus the assembled read block to the core.

Parameters:
ADDR_WIDTH, 64, byte address width on both sides
BLOCK_WIDTH, 512, cache block width in bits
AXI_DATA_WIDTH, 64, AXI data bus width; BEATS = BLOCK_WIDTH/AXI_DATA_WIDTH (default 8)

Ports:
i_clk  in  1  clock
i_arst  in  1  asynchronous active-high reset
i_axi_read_start  in  1  level request: read block
i_axi_write_start  in  1  level request: write block (priority over read)
i_axi_addr  in  ADDR_WIDTH  block address
i_data_block  in  BLOCK_WIDTH  write-back block
o_data_block  out  BLOCK_WIDTH  assembled read block
o_axi_done  out  1  one-cycle completion pulse
o_axi_err  out  1  sticky response error (see Optional Feature)
o_arvalid / i_arready  out/in  1  AR handshake
o_araddr  out  ADDR_WIDTH  AR address
o_arlen  out  8  AR burst length = BEATS-1
o_arsize  out  3  AR size = log2(AXI_DATA_WIDTH/8)
o_arburst  out  2  AR burst type = 2'b01 (INCR)
i_rvalid / o_rready  in/out  1  R handshake
i_rdata  in  AXI_DATA_WIDTH  read data
i_rresp  in  2  read response
i_rlast  in  1  last read beat
o_awvalid / i_awready  out/in  1  AW handshake
o_awaddr  out  ADDR_WIDTH  AW address
o_awlen  out  8  AW burst length = BEATS-1
o_awsize  out  3  AW size = log2(AXI_DATA_WIDTH/8)
o_awburst  out  2  AW burst type = 2'b01 (INCR)
o_wvalid / i_wready  out/in  1  W handshake
o_wdata  out  AXI_DATA_WIDTH  write data
o_wstrb  out  AXI_DATA_WIDTH/8  write strobes, all ones
o_wlast  out  1  last write beat
i_bvalid / o_bready  in/out  1  B handshake
i_bresp  in  2  write response

Behaviour:
- Reset:
  - Asynchronous; may arrive mid-burst; no completion of a pending burst is required.
  - State goes to IDLE.
  - All valid/ready outputs, o_axi_done, o_axi_err, beat counter, o_data_block and the write buffer are cleared to 0.
  - len/size/burst outputs are constant.
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE.
- IDLE:
  - Starts are sampled only in IDLE.
  - If write_start: latch aligned address (low log2(BLOCK_WIDTH/8) bits forced 0) and i_data_block into the internal buffer; go to WR.
  - Else if read_start: latch aligned address; go to RD_ADDR.
- RD_ADDR: o_arvalid=1 with stable o_araddr until i_arready; then go to RD_DATA with beat=0.
- RD_DATA:
  - o_rready=1.
  - Each i_rvalid beat writes o_data_block[beat*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]; beat 0 is the LSBs; beat increments.
  - On beat BEATS-1, go to DONE.
  - Termination is counter-based; i_rlast is not used for control.
- WR:
  - Enter with o_awvalid=1 and o_wvalid=1 simultaneously.
  - o_awvalid drops after the AW handshake.
  - o_wdata = buffer slice [beat]; it advances only on a W handshake.
  - o_wlast=1 exactly when beat==BEATS-1.
  - Valid and payload are held stable until ready. W may complete before AW.
  - Go to WR_RESP once both the AW handshake is done and the last W beat is accepted, including when both happen in the same cycle.
- WR_RESP: o_bready=1; on i_bvalid, go to DONE.
- DONE:
  - Exactly one cycle with o_axi_done=1, then IDLE.
  - This gives the cache FSM one cycle to update its start outputs, so a stale start is never relaunched.
- o_data_block holds its value until the next read beat overwrites it. Write bursts leave it unchanged.
- Latency with zero-wait slave:
  - Read: done 1+1+BEATS cycles after start is seen in IDLE (10 for defaults).
  - Write: BEATS+2 cycles (10).

Optional Feature:
AXI_ERR_CHECK_EN:
- Defined: o_axi_err is set and held until reset on any of:
  - rresp!=2'b00 on any beat;
  - bresp!=2'b00;
  - i_rlast mismatch (asserted on beat<BEATS-1, or absent on beat BEATS-1).
  - Transfer sequencing is unchanged.
- Undefined: responses and rlast are ignored; o_axi_err is tied 0.

Test Plan:
- Read, zero-wait slave: addr 0x1234 -> araddr 0x1200, arlen 7, arsize 3, arburst 1; beats 0x0..0x7 -> o_data_block = {7,6,..,0}; done pulse 10 cycles after start; one pulse only.
- Write with i_wready low 3 cycles and i_awready delayed until after the last W beat: block beats 0xA0..0xA7 -> wdata order A0..A7; wlast only on A7; payload stable while stalled; single done after B.
- Write-back then allocate: write_start held until done, read_start the next cycle -> exactly one AW burst then one AR burst; no duplicate burst.
- Both starts high in IDLE -> write burst issued first.
- Reset asserted mid RD_DATA after 3 beats -> all outputs 0 immediately; IDLE; next read completes normally.
- With AXI_ERR_CHECK_EN: bresp=2'b10 -> o_axi_err=1 and sticky across a later OKAY read. Without it: o_axi_err stays 0.
